lbm_field_reader: RTL and testbench
===================================

Name: lbm_field_reader

Overview:
- Readback engine for the LBM core's macroscopic field memories (density p, velocities ux, uy).
- On a start pulse it sweeps every cell address and returns the three Q8.56 words per cell on a valid/ready stream.
- The stream feeds the board-side export path (UART/host bridge).
- It is the reader for the memories the LBM core writes each time step.

Parameters:
- GRID_DIM, 256, number of lattice cells.
- ADDRESS_WIDTH, $clog2(GRID_DIM), memory address width.
- DATA_WIDTH, 64, field word width.
- FRACTIONAL_BITS, 56, fixed-point fraction bits (pass-through only; no arithmetic on data).
- INTEGER_BITS, DATA_WIDTH-FRACTIONAL_BITS, fixed-point integer bits.
- TIME_COUNT_WIDTH, 7, width of the time-step tag.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to dump the current fields; ignored while busy.
- time_step  in  TIME_COUNT_WIDTH  time-step tag, latched on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the final word is accepted.
- mem_rd_en  out  1  read strobe to the p/ux/uy memories.
- mem_addr  out  ADDRESS_WIDTH  shared read address.
- p_mem_data_out  in  DATA_WIDTH  density read data, valid 1 cycle after mem_rd_en.
- ux_mem_data_out  in  DATA_WIDTH  x-velocity read data, same latency.
- uy_mem_data_out  in  DATA_WIDTH  y-velocity read data, same latency.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  stream word.
- out_field  out  2  0=p, 1=ux, 2=uy, 3=header.
- out_last  out  1  high on the final word of the frame.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; address counter, hold and staging registers cleared. All outputs are registered.
- States:
  - IDLE: a start pulse moves to PRIME and latches time_step.
  - PRIME: drives mem_rd_en=1, mem_addr=0.
  - LOAD: captures the three data words into the hold register.
  - STREAM: presents hold[idx].
  - FINISH: pulses done, then returns to IDLE.
- Latency: with start sampled at edge k, out_valid rises after edge k+2 and the first word is p of cell 0.
- Handshake: a word transfers on a clock edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_field and out_last are held stable.
  - out_valid never drops without a transfer.
- Order per cell: p, ux, uy. Cells are emitted in ascending address order.
- Prefetch:
  - The read of cell a+1 issues in the cycle ux of cell a is accepted.
  - Its data lands in a staging register one cycle later.
  - On acceptance of uy of cell a, staging moves to hold.
  - Sustained throughput is 3 cycles per cell under constant out_ready. No bubbles between cells.
- Boundary:
  - No read is issued beyond GRID_DIM-1; the address counter does not wrap.
  - out_last=1 only on uy of cell GRID_DIM-1.
  - After that acceptance: out_valid=0 and busy=0 on the next edge, with done=1 for exactly that cycle.
- A start asserted while busy, or in the same cycle as done, is ignored. A new start is accepted from the cycle after done.
- Reset asserted mid-frame aborts immediately with no done pulse. Memory contents are untouched because the block never writes.
- mem_rd_en is 0 whenever no read is required. mem_addr holds its last value when not reading.

Optional Feature:
- Macro: LBM_FIELD_READER_HEADER_EN.
- Defined: before cell 0, one header word with out_field=3.
  - Bits [TIME_COUNT_WIDTH-1:0] = latched time_step.
  - Bits [47:32] = GRID_DIM.
  - All other bits 0.
  - The memory read for cell 0 overlaps the header.
  - out_valid still rises after edge k+2, and p of cell 0 follows the header with no bubble.
- Undefined: no header; out_field never equals 3.

Decomposition:
- Package lbm_pkg holds:
  - the field_code_t enum (P, UX, UY, HDR);
  - the default fixed-point constants (DATA_WIDTH, FRACTIONAL_BITS, INTEGER_BITS);
  - the reader FSM state typedef.
- One natural sub-module, lbm_cell_stager: the staging/hold register pair plus word-index mux and handshake logic. The top level keeps the FSM and address counter.

Test Plan:
- GRID_DIM=4, out_ready=1, memories preloaded with p=addr, ux=16+addr, uy=32+addr, start at edge 10:
  - out_valid from edge 12;
  - 12 words 0,16,32,1,17,33,… ending at 35 with out_last;
  - done at edge 24.
- Same preload, out_ready toggling 1,0,0,1 repeating: identical word sequence; outputs stable during stalls; mem_addr never exceeds 3.
- start re-pulsed while busy at the 5th word: ignored; exactly one frame and one done.
- RESET asserted after the 7th word: all outputs 0 asynchronously; next start yields a full frame from cell 0.
- GRID_DIM=256, out_ready=1: 768 words in 768 consecutive cycles; mem_rd_en pulses exactly 256 times.
- With LBM_FIELD_READER_HEADER_EN, time_step=99, GRID_DIM=4:
  - first word 0x0000_0004_0000_0063 with out_field=3;
  - then the 12 field words;
  - done one cycle later than without the header.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared types and fixed-point defaults for the LBM field readback path.
package lbm_pkg;

  localparam int LBM_DATA_WIDTH      = 64;
  localparam int LBM_FRACTIONAL_BITS = 56;
  localparam int LBM_INTEGER_BITS    = LBM_DATA_WIDTH - LBM_FRACTIONAL_BITS;

  typedef enum logic [1:0] {
    P   = 2'd0,
    UX  = 2'd1,
    UY  = 2'd2,
    HDR = 2'd3
  } field_code_t;

  typedef logic [2:0] rd_state_t;

  localparam rd_state_t S_IDLE   = 3'd0;
  localparam rd_state_t S_PRIME  = 3'd1;
  localparam rd_state_t S_LOAD   = 3'd2;
  localparam rd_state_t S_STREAM = 3'd3;
  localparam rd_state_t S_FINISH = 3'd4;

endpackage

// File: rtl/lbm_field_reader_if.sv
// Valid/ready word stream carrying field words out of the reader.
interface lbm_field_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_field;
  logic                  out_last;

  modport master (output out_valid, out_data, out_field, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_field, out_last, output out_ready);
endinterface

// File: rtl/lbm_field_reader_stager.sv
// Hold/staging register pair for one cell plus the word sequencer and stream handshake.
module lbm_cell_stager
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = LBM_DATA_WIDTH,
  parameter bit HDR_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] p_i,
  input  logic [DATA_WIDTH-1:0] ux_i,
  input  logic [DATA_WIDTH-1:0] uy_i,
  input  logic [DATA_WIDTH-1:0] hdr_word_i,
  lbm_field_reader_if.master    strm,
  output logic                  p_acc_o,
  output logic                  frame_end_o
);

  typedef logic [2:0][DATA_WIDTH-1:0] cell_t;

  cell_t                 hold_q, stage_q, mem_w, next_cell;
  logic                  valid_q, last_q, stage_cap_q, next_q, xfer;
  logic [DATA_WIDTH-1:0] data_q;
  field_code_t           field_q;

  assign mem_w       = {uy_i, ux_i, p_i};
  // Read data is only on the memory outputs in the cycle after the strobe; bypass staging then.
  assign next_cell   = stage_cap_q ? mem_w : stage_q;
  assign xfer        = valid_q && strm.out_ready;
  assign p_acc_o     = xfer && (field_q == P);
  assign frame_end_o = xfer && last_q;

  assign strm.out_valid = valid_q;
  assign strm.out_data  = data_q;
  assign strm.out_field = field_q;
  assign strm.out_last  = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      stage_q     <= '0;
      stage_cap_q <= 1'b0;
      next_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      field_q     <= P;
      last_q      <= 1'b0;
    end else begin
      stage_cap_q <= rd_en_i;
      if (stage_cap_q) stage_q <= mem_w;
      if (rd_en_i) next_q <= 1'b1;
      if (load_i) begin
        hold_q  <= mem_w;
        next_q  <= 1'b0;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
        field_q <= HDR_EN ? HDR : P;
        data_q  <= HDR_EN ? hdr_word_i : p_i;
      end else if (xfer) begin
        unique case (field_q)
          HDR: begin
            field_q <= P;
            data_q  <= hold_q[0];
          end
          P: begin
            field_q <= UX;
            data_q  <= hold_q[1];
          end
          UX: begin
            field_q <= UY;
            data_q  <= hold_q[2];
            // No prefetch for this cell means it is the final one.
            last_q  <= !(next_q || rd_en_i);
          end
          default: begin
            if (last_q) begin
              valid_q <= 1'b0;
              data_q  <= '0;
              field_q <= P;
              last_q  <= 1'b0;
            end else begin
              hold_q  <= next_cell;
              field_q <= P;
              data_q  <= next_cell[0];
              next_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/lbm_field_reader.sv
// Sweeps the p/ux/uy field memories and streams three words per cell.
// Define LBM_FIELD_READER_HEADER_EN to prefix each frame with a header word.
module lbm_field_reader
  import lbm_pkg::*;
#(
  parameter int GRID_DIM         = 256,
  parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM),
  parameter int DATA_WIDTH       = LBM_DATA_WIDTH,
  parameter int FRACTIONAL_BITS  = LBM_FRACTIONAL_BITS,
  parameter int INTEGER_BITS     = DATA_WIDTH - FRACTIONAL_BITS,
  parameter int TIME_COUNT_WIDTH = 7
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        start,
  input  logic [TIME_COUNT_WIDTH-1:0] time_step,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]       p_mem_data_out,
  input  logic [DATA_WIDTH-1:0]       ux_mem_data_out,
  input  logic [DATA_WIDTH-1:0]       uy_mem_data_out,
  lbm_field_reader_if.master          strm
);

`ifdef LBM_FIELD_READER_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(GRID_DIM - 1);

  if (INTEGER_BITS + FRACTIONAL_BITS != DATA_WIDTH) begin : g_fmt_chk
    $error("lbm_field_reader: INTEGER_BITS + FRACTIONAL_BITS must equal DATA_WIDTH");
  end

  rd_state_t                   state_q, state_d;
  logic                        busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [TIME_COUNT_WIDTH-1:0] time_q, time_d;
  logic                        p_acc, frame_end;
  logic [DATA_WIDTH-1:0]       hdr_word;

  always_comb begin
    hdr_word                         = '0;
    hdr_word[47:32]                  = 16'(GRID_DIM);
    hdr_word[TIME_COUNT_WIDTH-1:0]   = time_q;
  end

  // The next cell is fetched while the current cell's ux/uy are still streaming.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    time_d  = time_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PRIME;
        busy_d  = 1'b1;
        rd_en_d = 1'b1;
        addr_d  = '0;
        time_d  = time_step;
      end
      S_PRIME: state_d = S_LOAD;
      S_LOAD:  state_d = S_STREAM;
      S_STREAM: begin
        if (p_acc && addr_q != LastAddr) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
        if (frame_end) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      time_q  <= time_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;

  lbm_cell_stager #(
    .DATA_WIDTH (DATA_WIDTH),
    .HDR_EN     (HdrEn)
  ) u_stager (
    .clk         (CLOCK_50),
    .rst         (RESET),
    .load_i      (state_q == S_LOAD),
    .rd_en_i     (rd_en_q),
    .p_i         (p_mem_data_out),
    .ux_i        (ux_mem_data_out),
    .uy_i        (uy_mem_data_out),
    .hdr_word_i  (hdr_word),
    .strm        (strm),
    .p_acc_o     (p_acc),
    .frame_end_o (frame_end)
  );

endmodule

// File: tb/tb_lbm_field_reader.sv
// Directed bench for lbm_field_reader: a 4-cell instance for sequencing and a 256-cell instance for throughput.
module tb_lbm_field_reader;

`ifdef LBM_FIELD_READER_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0]  ts = 7'd99;
  logic        start4 = 1'b0, busy4, done4, rd4;
  logic [1:0]  addr4;
  logic [63:0] p4 = '0, ux4 = '0, uy4 = '0;
  logic        start256 = 1'b0, busy256, done256, rd256;
  logic [7:0]  addr256;
  logic [63:0] p256 = '0, ux256 = '0, uy256 = '0;

  lbm_field_reader_if #(.DATA_WIDTH(64)) s4 ();
  lbm_field_reader_if #(.DATA_WIDTH(64)) s256 ();

  lbm_field_reader #(.GRID_DIM(4)) dut4 (
    .CLOCK_50(clk), .RESET(rst), .start(start4), .time_step(ts),
    .busy(busy4), .done(done4), .mem_rd_en(rd4), .mem_addr(addr4),
    .p_mem_data_out(p4), .ux_mem_data_out(ux4), .uy_mem_data_out(uy4),
    .strm(s4.master)
  );

  lbm_field_reader #(.GRID_DIM(256)) dut256 (
    .CLOCK_50(clk), .RESET(rst), .start(start256), .time_step(ts),
    .busy(busy256), .done(done256), .mem_rd_en(rd256), .mem_addr(addr256),
    .p_mem_data_out(p256), .ux_mem_data_out(ux256), .uy_mem_data_out(uy256),
    .strm(s256.master)
  );

  // Synchronous-read memory models: p=addr, ux=step+addr, uy=2*step+addr.
  always @(posedge clk) if (rd4) begin
    p4 <= 64'(addr4); ux4 <= 64'(addr4) + 64'd16; uy4 <= 64'(addr4) + 64'd32;
  end
  always @(posedge clk) if (rd256) begin
    p256 <= 64'(addr256); ux256 <= 64'(addr256) + 64'd256; uy256 <= 64'(addr256) + 64'd512;
  end

  function automatic logic [63:0] exp_data(int i, int grid, int step);
    int j;
    j = i - H;
    if (j < 0) return (64'(grid) << 32) | 64'd99;
    return 64'((j % 3) * step + j / 3);
  endfunction

  function automatic logic [1:0] exp_field(int i);
    return (i < H) ? 2'd3 : 2'((i - H) % 3);
  endfunction

  function automatic logic exp_last(int i, int grid);
    return (i == 3 * grid - 1 + H);
  endfunction

  // Frame capture state for the 4-cell instance.
  int          nw, dones, rd_cnt, unstable, dropped, first_v, done_c;
  bit          tmo;
  logic [1:0]  rd_addr [8];
  logic [63:0] gd [16];
  logic [1:0]  gf [16];
  logic        gl [16];

  task automatic collect(input int mode, input bit repulse, input int stop_words,
                         input int extra, input int budget);
    bit          prev_stall = 1'b0, pulsed = 1'b0, rdy;
    logic [63:0] pd = '0;
    logic [1:0]  pf = '0;
    logic        pl = 1'b0;
    int          post = extra;
    int          ph = 0;
    nw = 0; dones = 0; rd_cnt = 0; unstable = 0; dropped = 0;
    first_v = -1; done_c = -1; tmo = 1'b1;
    for (int i = 0; i < 16; i++) begin gd[i] = 'x; gf[i] = 'x; gl[i] = 1'bx; end
    for (int c = 0; c < budget; c++) begin
      if (rd4) begin
        if (rd_cnt < 8) rd_addr[rd_cnt] = addr4;
        rd_cnt++;
      end
      if (prev_stall) begin
        if (!s4.out_valid) dropped++;
        else if (s4.out_data !== pd || s4.out_field !== pf || s4.out_last !== pl) unstable++;
      end
      if (s4.out_valid && first_v < 0) first_v = cyc;
      start4 = 1'b0;
      if (repulse && nw == 4 && !pulsed) begin start4 = 1'b1; pulsed = 1'b1; end
      if (done4) begin
        dones++;
        if (done_c < 0) done_c = cyc;
        if (repulse) start4 = 1'b1;
      end
      if (done_c >= 0 && stop_words == 0) begin
        if (post == 0) begin tmo = 1'b0; break; end
        post--;
      end
      rdy = (mode == 0) || (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
      s4.out_ready = rdy;
      prev_stall = s4.out_valid && !rdy;
      pd = s4.out_data; pf = s4.out_field; pl = s4.out_last;
      if (s4.out_valid && rdy) begin
        if (nw < 16) begin gd[nw] = s4.out_data; gf[nw] = s4.out_field; gl[nw] = s4.out_last; end
        nw++;
      end
      @(posedge clk); #1;
      if (stop_words > 0 && nw >= stop_words) begin tmo = 1'b0; break; end
    end
    start4 = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0/0", busy4, done4);
    end
    checks++;
    if (rd4 !== 1'b0 || addr4 !== 2'd0) begin
      errors++; $display("FAIL reset_mem: rd_en=%b addr=%0d, want 0/0", rd4, addr4);
    end
    checks++;
    if (s4.out_valid !== 1'b0 || s4.out_data !== 64'd0 || s4.out_field !== 2'd0 || s4.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_stream: valid=%b data=%h field=%0d last=%b, want all 0",
                         s4.out_valid, s4.out_data, s4.out_field, s4.out_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    while (cyc < 9) begin @(posedge clk); #1; end
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    checks++;
    if (cyc != 10 || busy4 !== 1'b1 || s4.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_start: edge=%0d busy=%b valid=%b, want 10/1/0", cyc, busy4, s4.out_valid);
    end
    collect(0, 1'b0, 0, 0, 100);
    checks++;
    if (tmo) begin errors++; $display("FAIL stream_timeout: done not seen, want done"); end
    checks++;
    if (first_v != 12) begin errors++; $display("FAIL stream_first_valid: edge %0d, want 12", first_v); end
    checks++;
    if (nw != 12 + H) begin errors++; $display("FAIL stream_count: %0d words, want %0d", nw, 12 + H); end
    for (int i = 0; i < 12 + H; i++) begin
      checks++;
      if (gd[i] !== exp_data(i, 4, 16) || gf[i] !== exp_field(i) || gl[i] !== exp_last(i, 4)) begin
        errors++; $display("FAIL stream_word%0d: got %h/%0d/%b want %h/%0d/%b", i, gd[i], gf[i], gl[i],
                           exp_data(i, 4, 16), exp_field(i), exp_last(i, 4));
      end
    end
    checks++;
    if (done_c != 24 + H || dones != 1) begin
      errors++; $display("FAIL stream_done: edge %0d count %0d, want edge %0d count 1", done_c, dones, 24 + H);
    end
    checks++;
    if (rd_cnt != 4 || rd_addr[0] !== 2'd0 || rd_addr[1] !== 2'd1 || rd_addr[2] !== 2'd2 || rd_addr[3] !== 2'd3) begin
      errors++; $display("FAIL stream_reads: %0d reads, want 4 at addresses 0..3", rd_cnt);
    end
    checks++;
    if (s4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL stream_end: valid=%b busy=%b with done, want 0/0", s4.out_valid, busy4);
    end
    @(posedge clk); #1;
    checks++;
    if (done4 !== 1'b0) begin errors++; $display("FAIL stream_done_width: done=%b one cycle later, want 0", done4); end
  endtask

  task automatic test_stall();
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL stall_accept: busy=%b after start, want 1", busy4); end
    collect(1, 1'b0, 0, 0, 200);
    checks++;
    if (tmo || nw != 12 + H) begin
      errors++; $display("FAIL stall_count: timeout=%0d words=%0d, want 0/%0d", tmo, nw, 12 + H);
    end
    for (int i = 0; i < 12 + H; i++) begin
      checks++;
      if (gd[i] !== exp_data(i, 4, 16) || gf[i] !== exp_field(i) || gl[i] !== exp_last(i, 4)) begin
        errors++; $display("FAIL stall_word%0d: got %h/%0d/%b want %h/%0d/%b", i, gd[i], gf[i], gl[i],
                           exp_data(i, 4, 16), exp_field(i), exp_last(i, 4));
      end
    end
    checks++;
    if (unstable != 0 || dropped != 0) begin
      errors++; $display("FAIL stall_hold: %0d changed, %0d dropped during stalls, want 0/0", unstable, dropped);
    end
    checks++;
    if (rd_cnt != 4 || rd_addr[3] !== 2'd3) begin
      errors++; $display("FAIL stall_reads: %0d reads, final addr %0d, want 4 reads ending at 3", rd_cnt, rd_addr[3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignore();
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    collect(0, 1'b1, 0, 3, 100);
    checks++;
    if (tmo || nw != 12 + H || dones != 1) begin
      errors++; $display("FAIL restart_frames: timeout=%0d words=%0d dones=%0d, want 0/%0d/1", tmo, nw, H + 12, dones);
    end
    checks++;
    if (rd_cnt != 4) begin errors++; $display("FAIL restart_reads: %0d reads, want 4", rd_cnt); end
    checks++;
    if (gd[11 + H] !== 64'd35 || gl[11 + H] !== 1'b1) begin
      errors++; $display("FAIL restart_last: got %h/%b, want 35/1", gd[11 + H], gl[11 + H]);
    end
    checks++;
    if (busy4 !== 1'b0 || s4.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart_idle: busy=%b valid=%b after frame, want 0/0", busy4, s4.out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    collect(0, 1'b0, 7, 0, 100);
    checks++;
    if (tmo || busy4 !== 1'b1) begin
      errors++; $display("FAIL abort_setup: timeout=%0d busy=%b, want 0/1", tmo, busy4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || rd4 !== 1'b0 || addr4 !== 2'd0) begin
      errors++; $display("FAIL abort_ctrl: busy=%b done=%b rd=%b addr=%0d, want all 0", busy4, done4, rd4, addr4);
    end
    checks++;
    if (s4.out_valid !== 1'b0 || s4.out_data !== 64'd0 || s4.out_field !== 2'd0 || s4.out_last !== 1'b0) begin
      errors++; $display("FAIL abort_stream: valid=%b data=%h field=%0d last=%b, want all 0",
                         s4.out_valid, s4.out_data, s4.out_field, s4.out_last);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    collect(0, 1'b0, 0, 0, 100);
    checks++;
    if (tmo || nw != 12 + H || dones != 1) begin
      errors++; $display("FAIL abort_refill: timeout=%0d words=%0d dones=%0d, want 0/%0d/1", tmo, nw, 12 + H, dones);
    end
    checks++;
    if (gd[H] !== 64'd0 || gf[H] !== 2'd0 || gd[1 + H] !== 64'd16 || gd[11 + H] !== 64'd35) begin
      errors++; $display("FAIL abort_order: words %h,%h..%h, want 0,10..23 hex", gd[H], gd[1 + H], gd[11 + H]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_grid256();
    int n = 0, rdc = 0, bad = 0, first = -1, lastc = -1, ks;
    bit seen = 1'b0;
    s256.out_ready = 1'b1;
    start256 = 1'b1; @(posedge clk); #1; start256 = 1'b0;
    ks = cyc;
    for (int c = 0; c < 1000; c++) begin
      if (rd256) rdc++;
      if (done256) begin seen = 1'b1; break; end
      if (s256.out_valid) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        if (s256.out_data !== exp_data(n, 256, 256) || s256.out_field !== exp_field(n) ||
            s256.out_last !== exp_last(n, 256)) bad++;
        n++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL g256_timeout: no done within 1000 cycles, want done"); end
    checks++;
    if (first != ks + 2) begin errors++; $display("FAIL g256_latency: first valid edge %0d, want %0d", first, ks + 2); end
    checks++;
    if (n != 768 + H || lastc - first + 1 != n) begin
      errors++; $display("FAIL g256_throughput: %0d words over %0d cycles, want %0d back to back",
                         n, lastc - first + 1, 768 + H);
    end
    checks++;
    if (rdc != 256) begin errors++; $display("FAIL g256_reads: %0d read strobes, want 256", rdc); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL g256_words: %0d wrong words, want 0", bad); end
  endtask

  initial begin
    s4.out_ready = 1'b0;
    s256.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_restart_ignore();
    test_reset_midframe();
    test_grid256();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
